// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that adds two WIDTH-bit operands one nibble per cycle through an
// external 4-bit adder, LSB nibble first, with the carry registered between nibbles.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NIB-1:0][3:0]  a_reg;
  logic [NIB-1:0][3:0]  b_reg;
  logic [NIB-1:0][3:0]  sum_reg;
  logic                 carry_reg;
  logic [IDX_W-1:0]     idx;
  logic                 accept;
  logic                 last_nib;

  assign accept   = in_valid && in_ready;
  assign last_nib = (idx == IDX_W'(NIB - 1));

  // Control and result state; the result is reset so sum/cout read 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            idx       <= '0;
            sum_reg   <= '0;
            carry_reg <= cin;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_sum;
          carry_reg    <= add_cout;
          if (!last_nib) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand capture is pure data and carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[idx];
        add_b   = b_reg[idx];
        add_cin = carry_reg;
        if (last_nib) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = sum_reg;
  assign cout = carry_reg;

endmodule
